// File: rtl/key_event_decoder.sv
// key_event_decoder
// Classifies debounced push-button press/release pulses into single-click,
// double-click, long-press and auto-repeat events. All outputs are registered.
//
// Ports:
//   i_clk    - system clock, rising edge
//   i_rst    - asynchronous active-low reset
//   i_pos    - one-cycle press pulse from the debouncer
//   i_neg    - one-cycle release pulse from the debouncer
//   o_single - one-cycle pulse, single click
//   o_double - one-cycle pulse, double click
//   o_long   - one-cycle pulse, long press detected
//   o_repeat - one-cycle pulse, auto-repeat tick while long-held
//   o_held   - level, button currently considered pressed
module key_event_decoder #(
  parameter int unsigned LONG_CYC   = 6_000_000,
  parameter int unsigned DBL_CYC    = 3_000_000,
  parameter int unsigned REPEAT_CYC = 1_200_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pos,
  input  logic i_neg,
  output logic o_single,
  output logic o_double,
  output logic o_long,
  output logic o_repeat,
  output logic o_held
);

  localparam int unsigned MAX_LD  = (LONG_CYC > DBL_CYC) ? LONG_CYC : DBL_CYC;
  localparam int unsigned MAX_CYC = (MAX_LD > REPEAT_CYC) ? MAX_LD : REPEAT_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC);

  // Terminal counts; the counter is cleared on reaching them so it never wraps.
  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DBL_TC    = CNT_W'(DBL_CYC - 1);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_GAP    = 3'd2,
    ST_PRESS2 = 3'd3,
    ST_LONG   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             single_q, single_d;
  logic             double_q, double_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             held_q, held_d;

  // Next-state, counter and event decisions. Inputs beat terminal counts.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    single_d = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_pos) begin
          state_d = ST_PRESS1;
          cnt_d   = '0;
        end
      end
      ST_PRESS1: begin
        if (i_neg) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else if (cnt_q == LONG_TC) begin
          state_d = ST_LONG;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (i_pos) begin
          state_d = ST_PRESS2;
          cnt_d   = '0;
        end else if (cnt_q == DBL_TC) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          single_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PRESS2: begin
        // Counter sits at zero here; no long detection on the second press.
        if (i_neg) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          double_d = 1'b1;
        end
      end
      ST_LONG: begin
        if (i_neg) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == REPEAT_TC) begin
          cnt_d    = '0;
          repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Held follows the state being entered, so it is high for each cycle spent pressed.
    held_d = (state_d == ST_PRESS1) || (state_d == ST_PRESS2) || (state_d == ST_LONG);
  end

  // State, counter and output registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      single_q <= single_d;
      double_q <= double_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
      held_q   <= held_d;
    end
  end

  assign o_single = single_q;
  assign o_double = double_q;
  assign o_long   = long_q;
  assign o_repeat = repeat_q;
  assign o_held   = held_q;

endmodule
